// File: rtl/fir_serial_pkg.sv
// Shared types for the FIR serial receiver: FSM encoding and the default sample format.
package fir_serial_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2,
    PUSH  = 2'd3
  } state_t;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered storage and count/flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             full_q;
  logic             empty_q;
  logic             do_wr;
  logic             do_rd;

  // A write into a full FIFO is only legal when a read frees the slot in the same cycle.
  assign do_rd   = rd_en && !empty_q;
  assign do_wr   = wr_en && (!full_q || do_rd);
  assign count_d = count_q + CW'(do_wr) - CW'(do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      assert (!(wr_en && full_q && !do_rd));
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/fir_serial_rx.sv
// Receives LSB-first serial words from the FIR, reassembles them and buffers them
// for a parallel valid/ready consumer.
module fir_serial_rx
  import fir_serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_sdin,
  input  logic                  i_sdin_valid,
  output logic                  o_sready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CNT_WIDTH-1:0]  o_frame_count
);

  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  sready_q, sready_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  push_c;
  logic                  fifo_full;
  logic                  fifo_empty;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sready_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sready_q  <= sready_d;
      cnt_q     <= cnt_d;
    end
  end

  // Bits enter at the MSB and shift down, so the first (LSB) bit lands in bit 0 after a full word.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sready_d  = sready_q;
    cnt_d     = cnt_q;
    push_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        sready_d = 1'b0;
        if (i_en && i_sdin_valid && !fifo_full) begin
          state_d  = ARM;
          sready_d = 1'b1;
        end
      end
      ARM: begin
        state_d   = SHIFT;
        bit_cnt_d = '0;
      end
      SHIFT: begin
        shift_d   = {i_sdin, shift_q[DATA_WIDTH-1:1]};
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
          state_d  = PUSH;
          sready_d = 1'b0;
        end
      end
      PUSH: begin
        push_c  = 1'b1;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .wr_en   (push_c),
    .wr_data (shift_q),
    .rd_en   (i_ready),
    .rd_data (o_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign o_valid       = !fifo_empty;
  assign o_sready      = sready_q;
  assign o_frame_count = cnt_q;

endmodule

// File: doc/fir_serial_rx.md
Name: fir_serial_rx

Overview:
Serial-to-parallel receiver directly downstream of the FIR top level. It consumes the FIR's LSB-first serial output stream through the FIR's valid/ready bit-serial handshake and reassembles each DATA_WIDTH-bit two's-complement sample. Samples are buffered in a small FIFO and presented on a parallel valid/ready interface to the next consumer, such as a DAC formatter or capture logic.

Parameters:
DATA_WIDTH, 24, sample width in bits; must match the FIR DATA_WIDTH.
FIFO_DEPTH, 2, parallel output buffer depth in words; power of two, >= 2.
CNT_WIDTH, 16, width of the received-word counter.

Ports:
i_clk  in  1  system clock; all logic on rising edge.
i_rst  in  1  asynchronous, active-low reset; i_rst=0 resets all state immediately.
i_en  in  1  enable; gates only the start of a new frame.
i_sdin  in  1  serial data from FIR o_dout, LSB first.
i_sdin_valid  in  1  FIR o_dout_valid; a word is pending upstream.
o_sready  out  1  to FIR i_ready; registered; held high for the whole capture window.
o_data  out  DATA_WIDTH  head-of-FIFO word, bit-exact (signed).
o_valid  out  1  FIFO non-empty.
i_ready  in  1  downstream accepts o_data when o_valid && i_ready at a rising edge.
o_frame_count  out  CNT_WIDTH  number of words pushed since reset; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (i_rst=0, async):
  - FSM goes to IDLE.
  - o_sready=0, o_valid=0, o_data=0, o_frame_count=0.
  - Shift register, bit counter and FIFO pointers cleared.
  - Any partial word is discarded.
- FSM states: IDLE, ARM, SHIFT, PUSH.
- IDLE:
  - Moves to ARM at edge E0 when i_en && i_sdin_valid && FIFO not full.
  - o_sready goes 1 from E0.
  - FIFO full or i_en=0: stays in IDLE, o_sready=0. No upstream handshake occurs (backpressure).
- ARM:
  - One cycle. At edge E1 the FIR samples o_sready=1.
  - Goes to SHIFT with bit_cnt=0. i_sdin is ignored.
- SHIFT:
  - At edges E2..E(DATA_WIDTH+1), samples i_sdin into bit position bit_cnt (LSB first).
  - On the edge sampling bit DATA_WIDTH-1: goes to PUSH and o_sready<=0.
  - i_sdin_valid and i_en are ignored once in SHIFT; the frame always completes.
- PUSH:
  - Writes the assembled word to the FIFO and increments o_frame_count.
  - Returns to IDLE.
  - The earliest next ARM is the following edge, i.e. two cycles after o_sready falls.
- Latency:
  - Word written at edge E(DATA_WIDTH+2).
  - If the FIFO was empty, o_valid=1 and o_data is valid in the cycle after that edge: DATA_WIDTH+2 cycles after E0.
- Space guarantee:
  - The not-full check at IDLE exit is sufficient, because FIFO occupancy can only decrease until the PUSH.
  - An overflow push is impossible; the FIFO asserts this.
- Parallel output:
  - Standard valid/ready.
  - o_data and o_valid are stable while o_valid && !i_ready.
  - First-word fall-through from registered FIFO storage.
- Simultaneous push and pop:
  - Occupancy unchanged.
  - When the FIFO is full, a pop in the same cycle as the IDLE check does not enable the start; not-full is evaluated on the registered count.
- Counter: o_frame_count wraps from 2^CNT_WIDTH-1 to 0 silently.

Decomposition:
- Package fir_serial_pkg contains:
  - state enum typedef {IDLE, ARM, SHIFT, PUSH}.
  - default DATA_WIDTH localparam.
  - sample_t typedef (logic signed [DATA_WIDTH-1:0]).
- One sub-module, sync_fifo, parameterised by width and depth:
  - registered storage, count register, full/empty flags;
  - simultaneous read/write supported;
  - also reused for any future parallel buffering.

Test Plan:
- Single word: FIR emits 0x800001 (most negative + 1); FIFO empty; i_ready=1 -> o_sready high for exactly 25 cycles from E0; o_data=0x800001 with o_valid one cycle, DATA_WIDTH+2=26 cycles after E0; o_frame_count=1.
- Backpressure: i_ready=0; FIR offers 0x000010, 0x7FFFFF, 0x123456 -> first two buffered (o_valid=1, o_data=0x000010); third gets no o_sready; pop one -> third captured; outputs in order 0x000010, 0x7FFFFF, 0x123456.
- Reset mid-frame: drop i_rst after 10 bits of 0xABCDEF -> o_sready=0 and o_valid=0 asynchronously; after release, a fresh 0x000001 is received correctly; o_frame_count=1.
- Enable gating: i_en=0 with i_sdin_valid=1 for 100 cycles -> o_sready stays 0; i_en=1 -> ARM on next edge; i_en dropped mid-SHIFT -> word still completes.
- Full-rate streaming: 220-sample 200 Hz sine, 24-bit, looped 4 times with i_ready=1 -> 880 words bit-exact to source, o_frame_count=880.
- Simultaneous push/pop: FIFO holds 1 word, pop coincides with PUSH edge -> occupancy stays 1, order preserved.
